// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-master round-robin arbiter for one shared AXI-Lite read channel
// One transaction in flight at a time: IDLE picks an owner, ADDR forwards the address, DATA returns the line.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_readAddr_addr,
  input  logic                  m0_readAddr_valid,
  output logic                  m0_readAddr_ready,
  output logic [DATA_WIDTH-1:0] m0_readData_data,
  output logic                  m0_readData_valid,
  input  logic                  m0_readData_ready,
  input  logic [ADDR_WIDTH-1:0] m1_readAddr_addr,
  input  logic                  m1_readAddr_valid,
  output logic                  m1_readAddr_ready,
  output logic [DATA_WIDTH-1:0] m1_readData_data,
  output logic                  m1_readData_valid,
  input  logic                  m1_readData_ready,
  output logic [ADDR_WIDTH-1:0] s_readAddr_addr,
  output logic                  s_readAddr_valid,
  input  logic                  s_readAddr_ready,
  input  logic [DATA_WIDTH-1:0] s_readData_data,
  input  logic                  s_readData_valid,
  output logic                  s_readData_ready,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;   // 1 = M1 was serviced last

  logic                  sel_m1;
  logic                  sel_addr_valid;
  logic                  sel_data_ready;
  logic [ADDR_WIDTH-1:0] sel_addr;

  assign sel_m1         = grant_q[1];
  assign sel_addr_valid = sel_m1 ? m1_readAddr_valid : m0_readAddr_valid;
  assign sel_data_ready = sel_m1 ? m1_readData_ready : m0_readData_ready;
  assign sel_addr       = sel_m1 ? m1_readAddr_addr  : m0_readAddr_addr;

  assign m0_readData_data = s_readData_data;
  assign m1_readData_data = s_readData_data;
  assign grant            = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d           = state;
    grant_d           = grant_q;
    last_d            = last_q;
    s_readAddr_valid  = 1'b0;
    s_readAddr_addr   = '0;
    s_readData_ready  = 1'b0;
    m0_readAddr_ready = 1'b0;
    m1_readAddr_ready = 1'b0;
    m0_readData_valid = 1'b0;
    m1_readData_valid = 1'b0;
    case (state)
      IDLE: begin
        if (m0_readAddr_valid || m1_readAddr_valid) begin
          // On a tie the master that was not serviced last wins
          if (m0_readAddr_valid && (!m1_readAddr_valid || last_q))
            grant_d = 2'b01;
          else
            grant_d = 2'b10;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_readAddr_valid  = sel_addr_valid;
        s_readAddr_addr   = sel_addr;
        m0_readAddr_ready = grant_q[0] & s_readAddr_ready;
        m1_readAddr_ready = grant_q[1] & s_readAddr_ready;
        if (!sel_addr_valid) begin
          // Owner withdrew its request; fairness history is left untouched
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (s_readAddr_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s_readData_ready  = sel_data_ready;
        m0_readData_valid = grant_q[0] & s_readData_valid;
        m1_readData_valid = grant_q[1] & s_readData_valid;
        if (s_readData_valid && sel_data_ready) begin
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - directed vector bench for axi_read_arbiter
// Each vector holds one cycle of inputs and the outputs expected in that cycle.
module tb_axi_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam logic [AW-1:0] A0 = 32'h0000_0100;
  localparam logic [AW-1:0] A1 = 32'h0000_2000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_readAddr_addr, m1_readAddr_addr, s_readAddr_addr;
  logic          m0_readAddr_valid, m0_readAddr_ready, m0_readData_valid, m0_readData_ready;
  logic          m1_readAddr_valid, m1_readAddr_ready, m1_readData_valid, m1_readData_ready;
  logic [DW-1:0] m0_readData_data, m1_readData_data, s_readData_data;
  logic          s_readAddr_valid, s_readAddr_ready, s_readData_valid, s_readData_ready;
  logic [1:0]    grant;

  int tests = 0;
  int fails = 0;

  axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_readAddr_addr(m0_readAddr_addr), .m0_readAddr_valid(m0_readAddr_valid),
    .m0_readAddr_ready(m0_readAddr_ready), .m0_readData_data(m0_readData_data),
    .m0_readData_valid(m0_readData_valid), .m0_readData_ready(m0_readData_ready),
    .m1_readAddr_addr(m1_readAddr_addr), .m1_readAddr_valid(m1_readAddr_valid),
    .m1_readAddr_ready(m1_readAddr_ready), .m1_readData_data(m1_readData_data),
    .m1_readData_valid(m1_readData_valid), .m1_readData_ready(m1_readData_ready),
    .s_readAddr_addr(s_readAddr_addr), .s_readAddr_valid(s_readAddr_valid),
    .s_readAddr_ready(s_readAddr_ready), .s_readData_data(s_readData_data),
    .s_readData_valid(s_readData_valid), .s_readData_ready(s_readData_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // ctl = {m0v, m1v, s_ar_ready, s_r_valid, m0_r_ready, m1_r_ready}
  // exp = {grant[1:0], s_ar_valid, m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, s_r_ready}
  typedef struct {
    logic          r;
    logic [5:0]    ctl;
    logic [7:0]    exp;
    logic [AW-1:0] addr;
    string         name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] c, input logic [7:0] e,
                     input logic [AW-1:0] a, input string n);
    vec_t v;
    v.r = r; v.ctl = c; v.exp = e; v.addr = a; v.name = n;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] sample();
    return {grant, s_readAddr_valid, m0_readAddr_ready, m1_readAddr_ready,
            m0_readData_valid, m1_readData_valid, s_readData_ready};
  endfunction

  task automatic check(input string n, input logic [AW-1:0] got, input logic [AW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, want);
    end
  endtask

  task automatic drive(input logic [5:0] c);
    {m0_readAddr_valid, m1_readAddr_valid, s_readAddr_ready,
     s_readData_valid, m0_readData_ready, m1_readData_ready} = c;
  endtask

  initial begin
    int lat;
    m0_readAddr_addr = A0;
    m1_readAddr_addr = A1;
    s_readData_data  = {16{8'hA5}};
    drive(6'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) add(0, 6'b000000, 8'b00000000, 0, "reset_idle");
    // M0 alone, data two cycles after address
    add(0, 6'b101010, 8'b00000000, 0,  "m0_req_idle");
    add(0, 6'b101010, 8'b01110000, A0, "m0_addr");
    add(0, 6'b001010, 8'b01000001, 0,  "m0_wait_data");
    add(0, 6'b001110, 8'b01000101, 0,  "m0_data");
    add(0, 6'b000000, 8'b00000000, 0,  "m0_done");
    add(1, 6'b000000, 8'b00000000, 0,  "rst_pulse");
    // Both held: strict alternation M0,M1,M0,M1; early s_r_valid ignored
    for (int k = 0; k < 2; k++) begin
      add(0, 6'b111111, 8'b00000000, 0,  "alt_idle0");
      add(0, 6'b111111, 8'b01110000, A0, "alt_addr_m0");
      add(0, 6'b111111, 8'b01000101, 0,  "alt_data_m0");
      add(0, 6'b111111, 8'b00000000, 0,  "alt_idle1");
      add(0, 6'b111111, 8'b10101000, A1, "alt_addr_m1");
      add(0, 6'b111111, 8'b10000011, 0,  "alt_data_m1");
    end
    add(0, 6'b000000, 8'b00000000, 0, "alt_done");
    // M1 stalled in ADDR while M0 waits; then M0 stalls data ready
    add(0, 6'b010000, 8'b00000000, 0, "stall_req_m1");
    for (int k = 0; k < 5; k++) add(0, 6'b110000, 8'b10100000, A1, "stall_addr_m1");
    add(0, 6'b111000, 8'b10101000, A1, "stall_hs_m1");
    add(0, 6'b100101, 8'b10000011, 0,  "stall_data_m1");
    add(0, 6'b100000, 8'b00000000, 0,  "late_req_m0");
    add(0, 6'b101000, 8'b01110000, A0, "late_addr_m0");
    for (int k = 0; k < 3; k++) add(0, 6'b000100, 8'b01000100, 0, "rready_low_m0");
    add(0, 6'b000110, 8'b01000101, 0, "rready_hs_m0");
    add(0, 6'b000000, 8'b00000000, 0, "rready_done");
    // Withdrawn request returns to IDLE and leaves last_q = M0
    add(0, 6'b010000, 8'b00000000, 0,  "abort_req_m1");
    add(0, 6'b000000, 8'b10000000, 0,  "abort_addr_m1");
    add(0, 6'b000000, 8'b00000000, 0,  "abort_idle");
    add(0, 6'b110000, 8'b00000000, 0,  "abort_tie");
    add(0, 6'b110000, 8'b10100000, A1, "abort_tie_m1");
    add(0, 6'b000000, 8'b10000000, 0,  "abort_again");
    add(0, 6'b000000, 8'b00000000, 0,  "abort_done");
    // Reset in DATA restores last_q = M1, so M0 wins the next tie
    add(0, 6'b111000, 8'b00000000, 0,  "rd_tie");
    add(0, 6'b111000, 8'b10101000, A1, "rd_addr_m1");
    add(1, 6'b000001, 8'b10000001, 0,  "rd_data_rst");
    add(0, 6'b000000, 8'b00000000, 0,  "rd_after_rst");
    add(0, 6'b111000, 8'b00000000, 0,  "rd_tie2");
    add(0, 6'b111000, 8'b01110000, A0, "rd_addr_m0");
    add(0, 6'b000110, 8'b01000101, 0,  "rd_data_m0");
    add(0, 6'b000000, 8'b00000000, 0,  "rd_done");

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      rst = vecs[i].r;
      drive(vecs[i].ctl);
      #1;
      check(vecs[i].name, {24'd0, sample()}, {24'd0, vecs[i].exp});
      if (vecs[i].exp[5]) check({vecs[i].name, "_addr"}, s_readAddr_addr, vecs[i].addr);
      @(negedge clk);
    end
    rst = 1'b0;

    // Hand sequence: request-to-address latency, slow memory, data broadcast
    m0_readAddr_addr = 32'h0000_0A40;
    drive(6'b100000);
    lat = 0;
    @(posedge clk); #1;
    while (!s_readAddr_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ar_latency", lat, 0);
    check("ar_addr", s_readAddr_addr, 32'h0000_0A40);
    @(negedge clk);
    drive(6'b101000);
    @(negedge clk);
    drive(6'b000010);
    repeat (2) @(negedge clk);
    #1;
    check("slow_no_valid", {31'd0, m0_readData_valid}, 0);
    s_readData_data = {8{16'h3C5A}};
    drive(6'b000110);
    #1;
    check("slow_valid", {30'd0, m0_readData_valid, m1_readData_valid}, 32'd2);
    check("bcast_m0", m0_readData_data[31:0], 32'h3C5A3C5A);
    check("bcast_m1", m1_readData_data[127:96], 32'h3C5A3C5A);
    @(negedge clk);
    drive(6'b000000);
    #1;
    check("slow_done", {24'd0, sample()}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI-Lite read channel (addr + data) to main memory between two cache masters: M0 = instruction cache, M1 = data cache.
- Sits between the CPU's cache read ports and the memory slave. One outstanding transaction at a time.
- Round-robin arbitration, with M0 winning the first tie after reset.
- Write channels are not handled here; they route directly from the data cache.

Parameters:
ADDR_WIDTH, 32, read address width
DATA_WIDTH, 128, read data (cache line) width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
m0_readAddr_addr  input  ADDR_WIDTH  M0 read address
m0_readAddr_valid  input  1  M0 address valid
m0_readAddr_ready  output  1  M0 address accepted
m0_readData_data  output  DATA_WIDTH  read data to M0
m0_readData_valid  output  1  M0 data valid
m0_readData_ready  input  1  M0 data accept
m1_readAddr_addr  input  ADDR_WIDTH  M1 read address
m1_readAddr_valid  input  1  M1 address valid
m1_readAddr_ready  output  1  M1 address accepted
m1_readData_data  output  DATA_WIDTH  read data to M1
m1_readData_valid  output  1  M1 data valid
m1_readData_ready  input  1  M1 data accept
s_readAddr_addr  output  ADDR_WIDTH  address to memory
s_readAddr_valid  output  1  address valid to memory
s_readAddr_ready  input  1  memory accepts address
s_readData_data  input  DATA_WIDTH  memory read data
s_readData_valid  input  1  memory data valid
s_readData_ready  output  1  arbiter/master accepts data
grant  output  2  one-hot current owner ({M1,M0}); 00 in IDLE

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- State encoding: `state` ∈ {IDLE, ADDR, DATA}; `grant_q` selects M0/M1; `last_q` records the last serviced master.
- Reset values:
  - state = IDLE, grant = 00, last_q = M1 (so M0 wins the first tie).
  - All valid/ready outputs = 0; s_readAddr_addr = 0.
- IDLE:
  - If only one master's readAddr_valid is set, grant it.
  - If both are set, grant the master != last_q.
  - Grant is registered; go to ADDR on the next edge. No slave signal is asserted in IDLE.
- ADDR:
  - s_readAddr_valid = granted master's readAddr_valid.
  - s_readAddr_addr = granted master's addr, muxed combinationally. Masters hold addr stable until ready, per AXI.
  - Granted master's readAddr_ready = s_readAddr_ready. Non-granted readAddr_ready = 0.
  - On handshake (valid & ready): go to DATA.
  - If the granted valid drops before handshake: return to IDLE, grant = 00, last_q unchanged.
- DATA:
  - Granted master's readData_valid = s_readData_valid.
  - s_readData_ready = granted master's readData_ready.
  - s_readData_data is broadcast to both m*_readData_data; non-granted readData_valid = 0.
  - On data handshake: last_q ← grant_q; go to IDLE.
- Latency:
  - Request to s_readAddr_valid: 1 cycle.
  - Minimum 3 cycles per transaction plus memory latency.
  - Back-to-back requests from the same or the other master resume arbitration in the IDLE cycle after the data handshake.
- Fairness: with both masters continuously requesting, grants strictly alternate. Neither master waits more than one transaction.
- Request arrival during service:
  - A request arriving in ADDR/DATA waits; its ready stays 0.
  - A new request from the current owner is treated as a fresh IDLE request.
- s_readData_valid in IDLE or ADDR: ignored; s_readData_ready = 0 (slave protocol error, no state change).
- Reset mid-transaction: immediate return to IDLE with reset values. The slave must be reset concurrently.

Test Plan:
- Reset, no requests → grant=00; all valid/ready outputs 0 for 10 cycles.
- M0 requests addr 0x100 alone; slave ready immediately, data 0xA5..A5 after 2 cycles → s_readAddr_valid high 1 cycle after request with addr 0x100; m0_readData_valid with data; m1 outputs stay 0; grant 01→00.
- M0 (0x100) and M1 (0x2000) request the same cycle, both held → M0 served first, then M1. Continuous requests alternate M0, M1, M0, M1 over 4 transactions.
- M1 granted, s_readAddr_ready held low 5 cycles; M0 requests meanwhile → m0_readAddr_ready stays 0; M0 is granted only after M1's data handshake.
- Granted master holds readData_ready low 3 cycles while s_readData_valid is high → s_readData_ready low, state stays DATA; completes on the ready cycle.
- rst asserted during DATA → next cycle grant=00, state IDLE, last_q=M1. Following simultaneous requests grant M0 first.
